// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI-lite memory arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

    // One-hot owner of a channel: bit 0 = CPU, bit 1 = GPU.
    typedef logic [1:0] gnt_t;

    localparam bit M_CPU = 1'b0;
    localparam bit M_GPU = 1'b1;

endpackage

// File: rtl/axi_mem_arbiter_rr_arb2.sv
// Two-way grant logic for one channel of axi_mem_arbiter.
// Default: round-robin, pointer holds the last completed owner.
// ARB_CPU_PRIO_EN: fixed priority, CPU wins; no pointer register exists.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  gnt_t req_i,
    input  logic advance_i,
    input  gnt_t owner_i,
    output gnt_t gnt_o
);

`ifdef ARB_CPU_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, advance_i, owner_i};

    // CPU always beats the GPU on a simultaneous request
    always_comb begin
        gnt_o = '0;
        if (req_i[M_CPU])      gnt_o[M_CPU] = 1'b1;
        else if (req_i[M_GPU]) gnt_o[M_GPU] = 1'b1;
    end
`else
    logic last_q, last_d;

    // last completed owner; reset to GPU so the CPU wins the first contest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

    // record the owner whose transaction just completed
    always_comb begin
        last_d = last_q;
        if (advance_i) last_d = owner_i[M_GPU];
    end

    // single requester wins outright; on a tie the non-last owner wins
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end
`endif

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI-lite slave port between CPU (m0) and mini-GPU (m1).
// Read and write channels are arbitrated independently; each channel holds
// one transaction and stays locked to its owner until the response completes.
// Optional macro ARB_CPU_PRIO_EN selects fixed CPU priority (see rr_arb2).
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   m0_awaddr,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [XLEN-1:0]   m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    input  logic [XLEN-1:0]   m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [XLEN-1:0]   m0_rdata,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [XLEN-1:0]   m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [XLEN-1:0]   m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    input  logic [XLEN-1:0]   m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [XLEN-1:0]   m1_rdata,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [XLEN-1:0]   s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [XLEN-1:0]   s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic              s_bvalid,
    output logic              s_bready,
    output logic [XLEN-1:0]   s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [XLEN-1:0]   s_rdata,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [1:0]        wr_gnt,
    output logic [1:0]        rd_gnt
);

    wr_state_e wr_q, wr_d;
    rd_state_e rd_q, rd_d;
    gnt_t      wgnt_q, wgnt_d, rgnt_q, rgnt_d;
    gnt_t      wreq, rreq, warb, rarb;
    logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic      w_adv, r_adv;
    logic      aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;

    logic [XLEN-1:0]   g_awaddr, g_wdata, g_araddr;
    logic [STRB_W-1:0] g_wstrb;
    logic              g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    assign wreq = {m1_awvalid | m1_wvalid, m0_awvalid | m0_wvalid};
    assign rreq = {m1_arvalid, m0_arvalid};

    rr_arb2 u_wr_arb (.clk(clk), .rst_n(rst_n), .req_i(wreq), .advance_i(w_adv),
                      .owner_i(wgnt_q), .gnt_o(warb));
    rr_arb2 u_rd_arb (.clk(clk), .rst_n(rst_n), .req_i(rreq), .advance_i(r_adv),
                      .owner_i(rgnt_q), .gnt_o(rarb));

    // state, grant and handshake-tracking registers for both channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= W_IDLE;
            rd_q      <= R_IDLE;
            wgnt_q    <= '0;
            rgnt_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            wgnt_q    <= wgnt_d;
            rgnt_q    <= rgnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // select the granted master's request signals; zero when nobody owns a channel
    always_comb begin
        g_awaddr = '0; g_awvalid = 1'b0; g_wdata = '0; g_wstrb = '0;
        g_wvalid = 1'b0; g_bready = 1'b0;
        g_araddr = '0; g_arvalid = 1'b0; g_rready = 1'b0;
        if (wgnt_q[M_GPU]) begin
            g_awaddr = m1_awaddr; g_awvalid = m1_awvalid; g_wdata = m1_wdata;
            g_wstrb  = m1_wstrb;  g_wvalid  = m1_wvalid;  g_bready = m1_bready;
        end else if (wgnt_q[M_CPU]) begin
            g_awaddr = m0_awaddr; g_awvalid = m0_awvalid; g_wdata = m0_wdata;
            g_wstrb  = m0_wstrb;  g_wvalid  = m0_wvalid;  g_bready = m0_bready;
        end
        if (rgnt_q[M_GPU]) begin
            g_araddr = m1_araddr; g_arvalid = m1_arvalid; g_rready = m1_rready;
        end else if (rgnt_q[M_CPU]) begin
            g_araddr = m0_araddr; g_arvalid = m0_arvalid; g_rready = m0_rready;
        end
    end

    // write FSM: grant in IDLE, pass AW and W independently, then route B
    always_comb begin
        wr_d = wr_q; wgnt_d = wgnt_q; aw_done_d = aw_done_q; w_done_d = w_done_q;
        w_adv = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        aw_rdy = 1'b0; w_rdy = 1'b0; b_vld = 1'b0;
        case (wr_q)
            W_IDLE: if (|wreq) begin
                wgnt_d = warb;
                wr_d   = W_REQ;
            end
            W_REQ: begin
                s_awvalid = g_awvalid & ~aw_done_q;
                s_wvalid  = g_wvalid & ~w_done_q;
                aw_rdy    = s_awready & ~aw_done_q;
                w_rdy     = s_wready & ~w_done_q;
                aw_done_d = aw_done_q | (s_awvalid & s_awready);
                w_done_d  = w_done_q | (s_wvalid & s_wready);
                if (aw_done_d && w_done_d) begin
                    wr_d      = W_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_RESP: begin
                s_bready = g_bready;
                b_vld    = s_bvalid;
                if (s_bvalid && g_bready) begin
                    wr_d   = W_IDLE;
                    wgnt_d = '0;
                    w_adv  = 1'b1;
                end
            end
            default: wr_d = W_IDLE;
        endcase
    end

    // read FSM: grant in IDLE, forward AR, then route R back to the owner
    always_comb begin
        rd_d = rd_q; rgnt_d = rgnt_q; r_adv = 1'b0;
        s_arvalid = 1'b0; s_rready = 1'b0; ar_rdy = 1'b0; r_vld = 1'b0;
        case (rd_q)
            R_IDLE: if (|rreq) begin
                rgnt_d = rarb;
                rd_d   = R_ADDR;
            end
            R_ADDR: begin
                s_arvalid = g_arvalid;
                ar_rdy    = s_arready;
                if (g_arvalid && s_arready) rd_d = R_DATA;
            end
            R_DATA: begin
                s_rready = g_rready;
                r_vld    = s_rvalid;
                if (s_rvalid && g_rready) begin
                    rd_d   = R_IDLE;
                    rgnt_d = '0;
                    r_adv  = 1'b1;
                end
            end
            default: rd_d = R_IDLE;
        endcase
    end

    assign s_awaddr = g_awaddr;
    assign s_wdata  = g_wdata;
    assign s_wstrb  = g_wstrb;
    assign s_araddr = g_araddr;

    assign m0_awready = aw_rdy & wgnt_q[M_CPU];
    assign m0_wready  = w_rdy  & wgnt_q[M_CPU];
    assign m0_bvalid  = b_vld  & wgnt_q[M_CPU];
    assign m0_arready = ar_rdy & rgnt_q[M_CPU];
    assign m0_rvalid  = r_vld  & rgnt_q[M_CPU];
    assign m0_rdata   = rgnt_q[M_CPU] ? s_rdata : '0;

    assign m1_awready = aw_rdy & wgnt_q[M_GPU];
    assign m1_wready  = w_rdy  & wgnt_q[M_GPU];
    assign m1_bvalid  = b_vld  & wgnt_q[M_GPU];
    assign m1_arready = ar_rdy & rgnt_q[M_GPU];
    assign m1_rvalid  = r_vld  & rgnt_q[M_GPU];
    assign m1_rdata   = rgnt_q[M_GPU] ? s_rdata : '0;

    assign wr_gnt = wgnt_q;
    assign rd_gnt = rgnt_q;

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Shares the single AXI-lite memory port between two masters: m0 = CPU (cpu_top), m1 = mini-GPU.
- Read and write channels are arbitrated independently, so one read and one write can be in flight at once.
- Each channel carries one transaction at a time and stays locked to the granted master until its response handshake completes.
- Sits between the two master ports and the memory/cache slave port.

Parameters:
XLEN, 32, address/data width
STRB_W, XLEN/8, write strobe width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
mN_awaddr/mN_awvalid/mN_awready  in/in/out  XLEN/1/1  write-address channel, master N (N=0,1)
mN_wdata/mN_wstrb/mN_wvalid/mN_wready  in/in/in/out  XLEN/STRB_W/1/1  write-data channel, master N
mN_bvalid/mN_bready  out/in  1/1  write response, master N
mN_araddr/mN_arvalid/mN_arready  in/in/out  XLEN/1/1  read-address channel, master N
mN_rdata/mN_rvalid/mN_rready  out/out/in  XLEN/1/1  read data, master N
s_awaddr/s_awvalid/s_awready  out/out/in  XLEN/1/1  slave write-address channel
s_wdata/s_wstrb/s_wvalid/s_wready  out/out/out/in  XLEN/STRB_W/1/1  slave write-data channel
s_bvalid/s_bready  in/out  1/1  slave write response
s_araddr/s_arvalid/s_arready  out/out/in  XLEN/1/1  slave read-address channel
s_rdata/s_rvalid/s_rready  in/in/out  XLEN/1/1  slave read data
wr_gnt/rd_gnt  output  2/2  one-hot current owner of each channel (debug)

Behaviour:
- Reset (async on rst_n low):
  - both FSMs go to IDLE; all valid/ready outputs 0; gnt = 2'b00.
  - rr pointers set so m0 wins the first contest.
  - s_awaddr/s_wdata/s_araddr drive 0.
- Write FSM states: W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
  - W_IDLE: request = mN_awvalid | mN_wvalid. On a cycle with any request, register the grant and enter W_REQ the next cycle. No handshakes occur in W_IDLE.
  - W_REQ: s_aw*/s_w* are combinational muxes of the granted master; s_awvalid = gm_awvalid & !aw_done, s_wvalid = gm_wvalid & !w_done.
  - W_REQ: gm_awready = s_awready & !aw_done, likewise for W. aw_done/w_done set on their handshakes, in either order or the same cycle.
  - W_REQ -> W_RESP once both done flags are set (including same-cycle completion); flags clear on that transition.
  - W_RESP: s_bready = gm_bready; gm_bvalid = s_bvalid. Return to W_IDLE on s_bvalid & s_bready and advance the rr pointer.
- Read FSM states: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_ADDR: forward AR of the granted master.
  - R_DATA: forward R. Complete on s_rvalid & s_rready, then advance the pointer.
- Ungranted master: all its ready/valid outputs held 0; its request stays pending. Its rdata output is driven 0.
- Arbitration:
  - Round-robin per channel; pointer = last completed owner.
  - Both masters requesting in IDLE: the non-last owner wins.
  - Single requester always wins immediately.
- Minimum latency: 1 cycle from request to first slave valid. Back-to-back transactions from alternating masters incur 1 idle cycle each.
- Slave bvalid/rvalid arriving in any state other than RESP/DATA: ignored; s_bready/s_rready held 0 there.
- rst_n asserted mid-transaction: transaction is abandoned, no response is forwarded, FSM returns to IDLE.
- All outputs from one always_ff state register plus combinational muxing; no combinational path from mN_*valid to s_*valid in IDLE.

Optional Feature:
- ARB_CPU_PRIO_EN defined: fixed priority, m0 (CPU) always wins simultaneous requests on both channels; rr pointers are not instantiated.
- Undefined: round-robin as above.

Decomposition:
- Package axi_arb_pkg holds:
  - wr_state_e {W_IDLE, W_REQ, W_RESP} and rd_state_e {R_IDLE, R_ADDR, R_DATA}.
  - typedef logic [1:0] gnt_t.
  - constant M_CPU = 0, M_GPU = 1.
- Sub-module rr_arb2: 2-way grant logic with pointer, inputs req[1:0] and advance, output one-hot gnt. Instantiated once per channel; honours ARB_CPU_PRIO_EN.

Test Plan:
- m0 write addr 0x100, data 0xDEADBEEF, wstrb 0xF, slave ready after 2 cycles -> s_awaddr = 0x100 and s_wdata = 0xDEADBEEF; m0_bvalid pulses once; wr_gnt = 01 throughout; m1_awready stays 0.
- m0 and m1 both arvalid in the same cycle after reset (addrs 0x10, 0x20) -> m0 served first, then m1; slave sees 0x10 then 0x20; m1_rdata = 0x1020 with a +0x1000 stub.
- Slave accepts W two cycles before AW on an m1 write -> w_done holds; W is not re-issued; exactly one s_wvalid handshake; bvalid routed to m1 only.
- Concurrent m0 write and m1 read -> both progress in parallel; wr_gnt = 01 and rd_gnt = 10 simultaneously.
- Four consecutive reads with both masters continuously requesting -> grant order m0, m1, m0, m1 (with ARB_CPU_PRIO_EN: m0 four times).
- rst_n low while in R_DATA -> all valid/ready outputs 0 immediately; after release, rd_gnt = 00 and a new request is served normally.
